// File: rtl/data_mem_pkg.sv
// Address map and region decode for the CPU data-memory port.
// Latency: n/a (constants and a combinational decode helper).
// Backpressure: n/a.
package data_mem_pkg;

  // I/O window occupies 0x0000 .. RAM_BEGIN-1; the CPU core's STACK_BEGIN tracks RAM_BEGIN.
  localparam logic [15:0] INPUT_ADDR  = 16'h0000;
  localparam logic [15:0] SEG1_ADDR   = 16'h0001;
  localparam logic [15:0] SEG2_ADDR   = 16'h0002;
  localparam logic [15:0] STATUS_ADDR = 16'h0003;
  localparam logic [15:0] RAM_BEGIN   = 16'h0010;

  typedef enum logic [2:0] {
    REG_INPUT,
    REG_SEG1,
    REG_SEG2,
    REG_STATUS,
    REG_RAM,
    REG_NONE,
    REG_OOB
  } region_t;

  // Priority decode of a word address. The RAM upper bound is compared in
  // 32 bits so a RAM window reaching 0xFFFF cannot wrap.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input int unsigned ram_words);
    region_t r;
    if (addr == INPUT_ADDR)                                    r = REG_INPUT;
    else if (addr == SEG1_ADDR)                                r = REG_SEG1;
    else if (addr == SEG2_ADDR)                                r = REG_SEG2;
    else if (addr == STATUS_ADDR)                              r = REG_STATUS;
    else if (addr < RAM_BEGIN)                                 r = REG_NONE;
    else if ({16'h0, addr} < ({16'h0, RAM_BEGIN} + ram_words)) r = REG_RAM;
    else                                                       r = REG_OOB;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word RAM, written to map onto block RAM; contents are never reset.
// Latency: 1 clock read, read-before-write on a same-address write.
// Backpressure: none; one access per clock.
//   clock - rising-edge clock     we - write strobe     addr - word index
//   wdat  - write data            rdat - registered read data (old word on write)
module data_mem_ram
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdat,
  output logic [15:0]          rdat
);

  logic [15:0] mem [2**ADDR_BITS];
  logic [15:0] rdat_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdat;
    end
    rdat_q <= mem[addr];
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the stack CPU data port: I/O window (switches, SEG1/2, status) plus word RAM.
// Latency: 1 clock read every cycle (read-before-write); writes land on the sampling edge.
// Backpressure: none; the CPU may issue an access every clock.
//   clock, reset_n            - clock and async active-low reset
//   address_ram/data_ram/wren_ram -> q_ram : CPU data port
//   switches -> (2-flop sync) ; SEG1/SEG2 : display registers
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address_ram,
  input  logic [15:0] data_ram,
  input  logic        wren_ram,
  output logic [15:0] q_ram,
  input  logic [15:0] switches,
  output logic [15:0] SEG1,
  output logic [15:0] SEG2
);

  localparam int unsigned RAM_WORDS = 32'd1 << RAM_ADDR_BITS;

  region_t                  region;
  region_t                  region_d, region_q;
  logic [15:0]              io_rd_d, io_rd_q;
  logic [15:0]              sync1_d, sync1_q;
  logic [15:0]              sync2_d, sync2_q;
  logic [15:0]              seg1_d, seg1_q;
  logic [15:0]              seg2_d, seg2_q;
  logic                     chg_d, chg_q;
  logic                     oob_d, oob_q;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     ram_we;
  logic [15:0]              ram_rdat;

  assign region  = decode_region(address_ram, RAM_WORDS);
  assign ram_idx = RAM_ADDR_BITS'(address_ram - RAM_BEGIN);
  // The RAM has no reset, so a write must be squashed while reset is held.
  assign ram_we  = wren_ram && (region == REG_RAM) && reset_n;

  data_mem_ram #(
    .ADDR_BITS (RAM_ADDR_BITS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdat  (data_ram),
    .rdat  (ram_rdat)
  );

  always_comb begin
    sync1_d  = switches;
    sync2_d  = sync1_q;
    seg1_d   = seg1_q;
    seg2_d   = seg2_q;
    region_d = region;
    io_rd_d  = 16'h0000;
    chg_d    = chg_q;
    oob_d    = oob_q;

    // A status read clears the sticky bits; a same-edge set event overrides it.
    if (region == REG_STATUS) begin
      chg_d = 1'b0;
      oob_d = 1'b0;
    end
    if (sync2_q != sync1_q) chg_d = 1'b1;
    if (region == REG_OOB)  oob_d = 1'b1;

    case (region)
      REG_INPUT:  io_rd_d = sync2_q;
      REG_SEG1: begin
        io_rd_d = seg1_q;
        if (wren_ram) seg1_d = data_ram;
      end
      REG_SEG2: begin
        io_rd_d = seg2_q;
        if (wren_ram) seg2_d = data_ram;
      end
      REG_STATUS: io_rd_d = {13'b0, oob_q, chg_q, 1'b1};
      default:    io_rd_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 16'h0000;
      sync2_q  <= 16'h0000;
      seg1_q   <= 16'h0000;
      seg2_q   <= 16'h0000;
      region_q <= REG_NONE;
      io_rd_q  <= 16'h0000;
      chg_q    <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
      region_q <= region_d;
      io_rd_q  <= io_rd_d;
      chg_q    <= chg_d;
      oob_q    <= oob_d;
    end
  end

  // Region registered alongside the access steers between the RAM output and I/O data.
  assign q_ram = (region_q == REG_RAM) ? ram_rdat : io_rd_q;
  assign SEG1  = seg1_q;
  assign SEG2  = seg2_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clock;
  logic        reset_n;
  logic [15:0] address_ram;
  logic [15:0] data_ram;
  logic        wren_ram;
  logic [15:0] q_ram;
  logic [15:0] switches;
  logic [15:0] SEG1;
  logic [15:0] SEG2;

  int n_total = 0;
  int n_bad   = 0;

  data_mem_responder #(.RAM_ADDR_BITS(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address_ram (address_ram),
    .data_ram    (data_ram),
    .wren_ram    (wren_ram),
    .q_ram       (q_ram),
    .switches    (switches),
    .SEG1        (SEG1),
    .SEG2        (SEG2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Set up one access to be sampled at the next edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
    address_ram = a;
    data_ram    = d;
    wren_ram    = w;
  endtask

  initial begin
    reset_n  = 1'b0;
    switches = 16'hA5A5;
    drive(16'h0000, 16'h0000, 1'b0);
    repeat (3) step();
    chk("rst_q", q_ram, 16'h0000);
    chk("rst_seg1", SEG1, 16'h0000);
    chk("rst_seg2", SEG2, 16'h0000);

    // Release; switch value reaches q_ram on the third edge.
    reset_n = 1'b1;
    step();
    step();
    chk("sync_not_yet", q_ram, 16'h0000);
    step();
    chk("sync_input", q_ram, 16'hA5A5);
    drive(16'h0003, 16'h0000, 1'b0);
    step();
    chk("status_after_rst", q_ram, 16'h0003);

    // RAM write then read; then read-before-write.
    drive(16'h0010, 16'h1234, 1'b1);
    step();
    drive(16'h0010, 16'h0000, 1'b0);
    step();
    chk("ram_rd", q_ram, 16'h1234);
    drive(16'h0010, 16'hBEEF, 1'b1);
    step();
    chk("ram_rbw_old", q_ram, 16'h1234);
    drive(16'h0010, 16'h0000, 1'b0);
    step();
    chk("ram_rbw_new", q_ram, 16'hBEEF);

    // Boundary: top word valid, top+1 out of bounds with no wrap.
    drive(16'h010F, 16'h5555, 1'b1);
    step();
    drive(16'h010F, 16'h0000, 1'b0);
    step();
    chk("ram_top", q_ram, 16'h5555);
    drive(16'h0110, 16'h7777, 1'b1);
    step();
    chk("oob_rd", q_ram, 16'h0000);
    drive(16'h0003, 16'h0000, 1'b0);
    step();
    chk("status_oob", q_ram, 16'h0005);
    step();
    chk("status_cleared", q_ram, 16'h0001);
    drive(16'h0010, 16'h0000, 1'b0);
    step();
    chk("oob_no_wrap", q_ram, 16'hBEEF);

    // Display registers and ignored writes.
    drive(16'h0001, 16'h00FF, 1'b1);
    step();
    chk("seg1_wr", SEG1, 16'h00FF);
    chk("seg2_kept", SEG2, 16'h0000);
    drive(16'h0002, 16'hC3C3, 1'b1);
    step();
    chk("seg2_wr", SEG2, 16'hC3C3);
    chk("seg1_kept", SEG1, 16'h00FF);
    drive(16'h0000, 16'h1111, 1'b1);
    step();
    drive(16'h0000, 16'h0000, 1'b0);
    step();
    chk("input_ro", q_ram, 16'hA5A5);
    drive(16'h0001, 16'h0000, 1'b0);
    step();
    chk("seg1_rd", q_ram, 16'h00FF);
    drive(16'h0005, 16'h9999, 1'b1);
    step();
    chk("unmapped_rd", q_ram, 16'h0000);
    drive(16'h0003, 16'h0000, 1'b0);
    step();
    chk("status_idle", q_ram, 16'h0001);

    // Collision: sw_changed sets on the same edge as a clearing STATUS read.
    switches = 16'h5A5A;
    drive(16'h0000, 16'h0000, 1'b0);
    step();
    drive(16'h0003, 16'h0000, 1'b0);
    step();
    chk("coll_preclear", q_ram, 16'h0001);
    step();
    chk("coll_set_wins", q_ram, 16'h0003);
    step();
    chk("coll_cleared", q_ram, 16'h0001);

    // Async reset in the middle of a RAM write.
    drive(16'h0020, 16'hABCD, 1'b1);
    step();
    drive(16'h0020, 16'hDEAD, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_seg1", SEG1, 16'h0000);
    chk("arst_q", q_ram, 16'h0000);
    step();
    reset_n = 1'b1;
    drive(16'h0020, 16'h0000, 1'b0);
    step();
    chk("arst_ram_kept", q_ram, 16'hABCD);
    chk("arst_seg1_after", SEG1, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
